// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and widths for the 16-bit load/store memory access unit.
package mem_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 16;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - 16-bit load/store sequenced as two big-endian byte accesses.
// Optional misaligned-address rejection under MEM_ALIGN_CHECK_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [BYTE_W-1:0] mem_wdata,
  input  logic [BYTE_W-1:0] mem_rdata
);

  state_t              state, next;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [BYTE_W-1:0]   hi_q;
  logic                err_q;
  logic                misalign;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = req_addr[0];
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next      = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    mem_addr  = addr_q;
    mem_write = 1'b0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next = misalign ? DONE : HI;
      end
      HI: begin
        mem_write = write_q;
        mem_wdata = wdata_q[WORD_W-1:BYTE_W];
        next      = LO;
      end
      LO: begin
        mem_addr  = addr_q + ADDR_W'(1);
        mem_write = write_q;
        mem_wdata = wdata_q[BYTE_W-1:0];
        next      = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        next      = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // The high byte is parked in hi_q so rsp_rdata only changes when a load completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      hi_q      <= '0;
      err_q     <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            write_q <= req_write;
            wdata_q <= req_wdata;
            err_q   <= misalign;
          end
        end
        HI: begin
          if (!write_q) hi_q <= mem_rdata;
        end
        LO: begin
          if (!write_q) rsp_rdata <= {hi_q, mem_rdata};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [15:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [15:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_write;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  logic [7:0] mem [256];

  int errors = 0;
  int checks = 0;
  int accepts = 0;
  int rsp_count = 0;

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  always @(posedge clk) begin
    if (req_valid && req_ready) accepts++;
    if (rsp_valid) rsp_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic er, output int lat,
                        output logic saw_w, output logic [AW-1:0] a_hi, output logic [AW-1:0] a_lo);
    int guard = 0;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat   = 1;
    saw_w = 1'b0;
    a_hi  = mem_addr;
    a_lo  = '0;
    while (!rsp_valid && lat < 10) begin
      saw_w = saw_w | mem_write;
      if (lat == 2) a_lo = mem_addr;
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0]   rd;
    logic          er;
    int            lat;
    logic          sw;
    logic [AW-1:0] ah, al;
    int            a0, r0, low;
    logic          bw [3];
    logic [AW-1:0] ba [3];
    logic [15:0]   bd [3];
    logic [15:0]   bexp [3];

    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 0);
    check("rst_rsp_err",   32'(rsp_err),   0);
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_mem_addr",  32'(mem_addr),  0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(1'b1, 8'h10, 16'hBEEF, rd, er, lat, sw, ah, al);
    check("st10_lat",    32'(lat), 3);
    check("st10_err",    32'(er), 0);
    check("st10_wr",     32'(sw), 1);
    check("st10_addrhi", 32'(ah), 'h10);
    check("st10_addrlo", 32'(al), 'h11);
    check("st10_mem10",  32'(mem[8'h10]), 'hBE);
    check("st10_mem11",  32'(mem[8'h11]), 'hEF);
    do_req(1'b0, 8'h10, 16'h0000, rd, er, lat, sw, ah, al);
    check("ld10_lat",   32'(lat), 3);
    check("ld10_rdata", 32'(rd), 'hBEEF);
    check("ld10_nowr",  32'(sw), 0);

`ifdef MEM_ALIGN_CHECK_EN
    mem[8'h05] <= 8'h3C;
    mem[8'h06] <= 8'h3C;
    #1;
    do_req(1'b1, 8'h05, 16'h1111, rd, er, lat, sw, ah, al);
    check("mis_lat",   32'(lat), 1);
    check("mis_err",   32'(er), 1);
    check("mis_nowr",  32'(sw), 0);
    check("mis_mem05", 32'(mem[8'h05]), 'h3C);
    check("mis_mem06", 32'(mem[8'h06]), 'h3C);
    check("mis_rdata", 32'(rd), 'hBEEF);
`else
    do_req(1'b1, 8'hFF, 16'h1234, rd, er, lat, sw, ah, al);
    check("wrap_lat",    32'(lat), 3);
    check("wrap_err",    32'(er), 0);
    check("wrap_addrlo", 32'(al), 'h00);
    check("wrap_memff",  32'(mem[8'hFF]), 'h12);
    check("wrap_mem00",  32'(mem[8'h00]), 'h34);
    do_req(1'b0, 8'hFF, 16'h0000, rd, er, lat, sw, ah, al);
    check("wrap_ld",     32'(rd), 'h1234);
`endif

    bw[0] = 1'b0; ba[0] = 8'h10; bd[0] = 16'h0000; bexp[0] = 16'hBEEF;
    bw[1] = 1'b1; ba[1] = 8'h30; bd[1] = 16'h5678; bexp[1] = 16'hBEEF;
    bw[2] = 1'b0; ba[2] = 8'h30; bd[2] = 16'h0000; bexp[2] = 16'h5678;
    a0 = accepts;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_write = bw[i];
      req_addr  = ba[i];
      req_wdata = bd[i];
      check("b2b_ready", 32'(req_ready), 1);
      @(posedge clk); #1;
      low = 0;
      rd  = 16'hxxxx;
      while (!req_ready && low < 10) begin
        if (rsp_valid) rd = rsp_rdata;
        low++;
        @(posedge clk); #1;
      end
      check("b2b_low_cycles", 32'(low), 3);
      check("b2b_rdata", 32'(rd), 32'(bexp[i]));
    end
    req_valid = 1'b0;
    check("b2b_accepts", 32'(accepts - a0), 3);
    repeat (4) @(posedge clk);
    #1;
    check("b2b_accepts_idle", 32'(accepts - a0), 3);

    mem[8'h20] <= 8'h00;
    mem[8'h21] <= 8'h77;
    #1;
    r0 = rsp_count;
    req_write = 1'b1;
    req_addr  = 8'h20;
    req_wdata = 16'hAA55;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rstlo_mem_write", 32'(mem_write), 1);
    check("rstlo_mem_addr",  32'(mem_addr), 'h21);
    rst_n = 1'b0;
    #1;
    check("rstlo_write_drop", 32'(mem_write), 0);
    check("rstlo_req_ready",  32'(req_ready), 1);
    check("rstlo_rsp_valid",  32'(rsp_valid), 0);
    check("rstlo_rsp_rdata",  32'(rsp_rdata), 0);
    check("rstlo_rsp_err",    32'(rsp_err),   0);
    check("rstlo_mem_addr0",  32'(mem_addr),  0);
    check("rstlo_mem_wdata",  32'(mem_wdata), 0);
    @(posedge clk); #1;
    check("rstlo_mem20", 32'(mem[8'h20]), 'hAA);
    check("rstlo_mem21", 32'(mem[8'h21]), 'h77);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rstlo_no_rsp", 32'(rsp_count - r0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
